// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream handshake plus memory port between loader (master) and its environment (slave).
interface prog_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  byte_valid;
  logic                  byte_ready;
  logic [DATA_WIDTH-1:0] byte_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  modport master (
    input  byte_valid, byte_data, mem_dout,
    output byte_ready, mem_we, mem_addr, mem_din
  );
  modport slave (
    output byte_valid, byte_data, mem_dout,
    input  byte_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads LENGTH stream bytes into memory from BASE_ADDR and holds the core off until done.
// Readback checksum verify is present only when PROG_LOADER_VERIFY_EN is defined.
module prog_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0010,
  parameter int                    LENGTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  prog_loader_if.master         bus,
  output logic                  owns_mem,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);
  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, VERIFY, DRAIN, DONE, ERROR} state_t;
  state_t state, next;
  logic [CW-1:0] count;
  logic accept, launch;
  assign bus.byte_ready = state == LOAD;
  assign accept = bus.byte_valid && bus.byte_ready;
  assign launch = start && (state == IDLE || state == DONE || state == ERROR);
  assign owns_mem = busy;
`ifdef PROG_LOADER_VERIFY_EN
  logic [DATA_WIDTH-1:0] rb_sum, rb_next;
  assign rb_next = rb_sum + bus.mem_dout;
`else
  logic unused_dout;
  assign unused_dout = ^bus.mem_dout;
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERROR: next = start ? LOAD : state;
      LOAD:              next = (accept && count == LAST) ? WAIT : LOAD;
`ifdef PROG_LOADER_VERIFY_EN
      WAIT:              next = VERIFY;
      VERIFY:            next = count == LAST ? DRAIN : VERIFY;
      DRAIN:             next = rb_next == checksum ? DONE : ERROR;
`else
      WAIT:              next = DONE;
`endif
      default:           next = IDLE;
    endcase
  end
  // status flags are registered from the next state so they change on the same edge as the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      checksum     <= '0;
      busy         <= 1'b0;
      core_hold    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      rb_sum       <= '0;
`endif
    end else begin
      bus.mem_we <= accept;
      busy       <= next == LOAD || next == WAIT || next == VERIFY || next == DRAIN;
      core_hold  <= next != IDLE && next != DONE;
      done       <= next == DONE;
      error      <= next == ERROR;
      if (launch) begin
        count    <= '0;
        checksum <= '0;
`ifdef PROG_LOADER_VERIFY_EN
        rb_sum   <= '0;
`endif
      end
      if (accept) begin
        bus.mem_addr <= BASE_ADDR + ADDR_WIDTH'(count);
        bus.mem_din  <= bus.byte_data;
        checksum     <= checksum + bus.byte_data;
        count        <= count + 1'b1;
      end
      if (state == WAIT) begin
        bus.mem_addr <= BASE_ADDR;
        count        <= '0;
      end
`ifdef PROG_LOADER_VERIFY_EN
      // read data lags the address by one cycle, so the first VERIFY edge has nothing to add
      if (state == VERIFY) begin
        bus.mem_addr <= bus.mem_addr + 1'b1;
        count        <= count + 1'b1;
        if (count != '0) rb_sum <= rb_next;
      end
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stream loads checked against a behavioural image/checksum/timing model.
module tb_prog_loader;
  localparam int L = 16;
  localparam logic [15:0] BASE = 16'h0010;
`ifdef PROG_LOADER_VERIFY_EN
  localparam int TAIL = L + 2;
`else
  localparam int TAIL = 1;
`endif
  logic clk = 0, reset = 1, start = 0;
  logic owns_mem, core_hold, busy, done, error;
  logic [7:0] checksum;
  logic [7:0] mem [65536];
  logic [7:0] img [L];
  bit corrupt = 0;
  int cyc = 0, n_checks = 0, n_err = 0;
  prog_loader_if bus();
  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .owns_mem(owns_mem), .core_hold(core_hold), .busy(busy),
    .done(done), .error(error), .checksum(checksum)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= (corrupt && bus.mem_addr == 16'h0013) ? mem[bus.mem_addr] ^ 8'h01 : mem[bus.mem_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_out"}, {bus.mem_we, bus.mem_addr, bus.mem_din, owns_mem, core_hold, busy, done, error, checksum}, 0);
    check({tag, "_rdy"}, bus.byte_ready, 0);
  endtask
  // mode 0 continuous, 1 valid on even cycles only, 2 random valid; mid>0 pulses start during the load
  task automatic run_load(input int mode, input bit bad, input int mid);
    int e, k, n, last, t;
    bit v;
    logic [7:0] sum = 0;
    foreach (img[i]) sum += img[i];
    corrupt = bad;
    @(negedge clk); start = 1;
    @(posedge clk); #1; e = cyc;
    check("start_done", done, 0);
    check("start_err", error, 0);
    check("start_busy", busy, 1);
    check("start_hold", core_hold, 1);
    check("start_sum", checksum, 0);
    n = 0; k = 0;
    while (n < L && k < 400) begin
      @(negedge clk); k++;
      start = (k == mid);
      v = mode == 0 ? 1'b1 : mode == 1 ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
      bus.byte_valid = v;
      bus.byte_data = v ? img[n] : 8'($urandom);
      check("byte_ready", bus.byte_ready, 1);
      @(posedge clk); #1;
      check("mem_we", bus.mem_we, v);
      if (v) begin
        check("mem_addr", bus.mem_addr, 32'(BASE + 16'(n)));
        check("mem_din", bus.mem_din, img[n]);
        n++;
      end
    end
    check("accepts", n, L);
    @(negedge clk); bus.byte_valid = 0; start = 0;
    last = k;
    t = cyc - e;
    while (!(done || error) && t < last + 3 * L + 10) begin
      if (t > last + 1) check("we_idle", bus.mem_we, 0);
      check("busy_run", busy, 1);
      check("hold_run", core_hold, 1);
      @(posedge clk); #1; t = cyc - e;
    end
    check("finish_t", t, last + TAIL);
    check("done", done, !bad);
    check("error", error, bad);
    check("checksum", checksum, sum);
    check("hold_end", core_hold, bad);
    check("owns_end", owns_mem, 0);
    check("busy_end", busy, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("we_after", bus.mem_we, 0);
`ifndef PROG_LOADER_VERIFY_EN
      check("addr_after", bus.mem_addr, 32'(BASE));
`endif
    end
    check("sticky", {done, error}, {!bad, bad});
    foreach (img[i]) check("mem", mem[BASE + 16'(i)], img[i]);
    corrupt = 0;
  endtask
  initial begin
    bus.byte_valid = 0; bus.byte_data = 0;
    start = 1;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk); reset = 0; start = 0;
    repeat (2) @(posedge clk);
    #1 check("idle_busy", busy, 0);
    foreach (img[i]) img[i] = 0;
    img[0] = 8'hA9; img[1] = 8'h04; img[2] = 8'h85; img[3] = 8'h02;
    run_load(0, 0, 0);
    check("sum_34", checksum, 8'h34);
    run_load(1, 0, 0);
`ifdef PROG_LOADER_VERIFY_EN
    run_load(0, 1, 0);
    check("bad_sum_34", checksum, 8'h34);
    run_load(0, 0, 0);
`endif
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 5; i++) begin
      bus.byte_valid = 1; bus.byte_data = 8'($urandom);
      @(negedge clk);
    end
    bus.byte_valid = 0; reset = 1;
    @(posedge clk); #1 check_zero("midreset");
    @(negedge clk); reset = 0;
    foreach (img[i]) img[i] = 8'($urandom);
    run_load(0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      foreach (img[i]) img[i] = 8'($urandom);
      run_load(2, 0, $urandom_range(2, 12));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program loader for the CPU core. Accepts a byte stream over a valid/ready handshake and writes it into memory from `BASE_ADDR` upward. Optionally reads the image back and compares checksums. Holds the core off memory until the image is in place. It replaces hand-driven memory preloading: its `owns_mem` output selects loader-versus-fetcher control of the memory address, data and write-enable, and `core_hold` keeps the fetcher/decoder idle.

## Interface
Parameters:
- `DATA_WIDTH`, 8, memory word / stream byte width
- `ADDR_WIDTH`, 16, memory address width
- `BASE_ADDR`, 16'h0010, first address written
- `LENGTH`, 16, bytes per image (≥1)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle load request
- `byte_valid`  in  1  stream byte present
- `byte_data`  in  DATA_WIDTH  stream byte
- `byte_ready`  out  1  loader accepts byte this cycle
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_din`  out  DATA_WIDTH  memory write data
- `mem_dout`  in  DATA_WIDTH  memory read data, valid one cycle after the address is presented
- `owns_mem`  out  1  loader drives memory; external mux selects loader over fetcher
- `core_hold`  out  1  core must not fetch
- `busy`  out  1  load or verify in progress
- `done`  out  1  sticky, image loaded (and verified)
- `error`  out  1  sticky, verify checksum mismatch
- `checksum`  out  DATA_WIDTH  mod-2^DATA_WIDTH sum of accepted bytes

## Operation
- States: IDLE, LOAD, WAIT, VERIFY, DRAIN, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → LOAD.
  - Clears the byte count, the load sum, the readback sum, `done` and `error`.
  - Sets `core_hold`.
- `start` is ignored in LOAD, WAIT, VERIFY and DRAIN.
- LOAD:
  - `byte_ready` is high for the whole state.
  - An accept is `byte_valid & byte_ready` at a rising edge. On accept:
    - `mem_we`←1, `mem_addr`←`BASE_ADDR`+count, `mem_din`←`byte_data`
    - checksum += byte
    - count++
  - With no accept, `mem_we`←0.
  - The LENGTH-th accept moves to WAIT.
  - A stalled stream waits indefinitely; no timeout.
- WAIT: one cycle in which the last write completes. At its edge:
  - `mem_we`←0 and `mem_addr`←`BASE_ADDR`.
  - Next state is VERIFY, or DONE when verify is compiled out.
- VERIFY: LENGTH cycles.
  - Cycle k presents `BASE_ADDR`+k.
  - From the second VERIFY edge onward, `mem_dout` is added to the readback sum.
  - After the LENGTH-th cycle → DRAIN.
- DRAIN: adds the final `mem_dout`, then compares the readback sum with `checksum`.
  - Equal → DONE.
  - Different → ERROR.
- DONE: `done`=1, `owns_mem`=0, `core_hold`=0.
- ERROR: `error`=1, `owns_mem`=0, `core_hold` stays 1.
- `owns_mem`=1 in LOAD, WAIT, VERIFY and DRAIN. `busy` has the same value.
- `mem_we` is 1 only in the cycle after an accept.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- `reset`, including mid-load, returns to IDLE at the next edge. Memory already written is left as is.

## Timing
- Reset values: all outputs 0, state IDLE.
- All outputs are registered except `byte_ready`, which decodes the state register directly.
- Let E be the edge sampling `start`:
  - `byte_ready` goes high after E.
  - With a continuous stream, accepts occur at E+1..E+LENGTH.
  - Memory writes land at E+2..E+LENGTH+1.
  - `done` rises at E+2·LENGTH+2 with verify, or E+LENGTH+1 without it.
- `start` coincident with `reset`: reset wins.
- Throughput: one byte per cycle, no bubbles.

## Configuration
- `PROG_LOADER_VERIFY_EN` defined:
  - VERIFY/DRAIN readback and checksum compare are present.
  - `error` is reachable.
- Not defined:
  - WAIT → DONE directly; no reads are issued.
  - `error` is tied 0 and `mem_dout` is unused.

## Test plan
- Continuous load, verify on, BASE 0x0010, LENGTH 16, bytes A9 04 85 02 then twelve 00:
  - writes go to 0x0010..0x001F;
  - `checksum`=0x34;
  - `done` at E+34, `error`=0, `core_hold` drops with `done`.
- Same image with `byte_valid` low every other cycle:
  - identical memory contents and checksum;
  - no write during stall cycles;
  - `done` later by 16 cycles.
- Memory model returns 03 instead of 02 at 0x0013 on readback:
  - `error`=1, `done`=0, `checksum`=0x34;
  - `core_hold` stays 1 and `owns_mem`=0.
- `reset` after the 5th accept:
  - next cycle all outputs are 0 and `byte_ready`=0;
  - a subsequent `start` restarts writing at 0x0010.
- `start` pulsed mid-LOAD:
  - no effect.
- `start` pulsed in DONE:
  - `done` clears and a fresh load begins with count 0.
- Macro off, continuous 16-byte load:
  - `done` at E+17;
  - `mem_we` never set after WAIT and `mem_addr` held at 0x0010;
  - `error`=0.
